// File: rtl/hid_pkg.sv
// Shared definitions for the HID event sequencer.
//   KEY_SLOTS  : key slots in a boot keyboard report
//   MOD_BITS   : modifier bits in a boot keyboard report
//   state_t    : sequencer FSM encoding (also driven on the debug state port)
//   key_set_t  : one report's worth of key slots, slot 0 in element [0]
package hid_pkg;
  localparam int KEY_SLOTS = 6;
  localparam int MOD_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    MOD     = 3'd2,
    BRK     = 3'd3,
    MAK     = 3'd4,
    COMMIT  = 3'd5
  } state_t;

  typedef logic [KEY_SLOTS-1:0][7:0] key_set_t;
endpackage

// File: rtl/hid_key_match.sv
// Combinational membership test: is `code` present in any slot of `set`.
//   code : byte to look for
//   set  : six key slots
//   hit  : 1 when at least one slot equals code
module hid_key_match
  import hid_pkg::*;
(
  input  logic [7:0] code,
  input  key_set_t   set,
  output logic       hit
);
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < KEY_SLOTS; i++) begin
      if (set[i] == code) hit = 1'b1;
    end
  end
endmodule

// File: rtl/hid_event_sequencer.sv
// Turns successive HID boot keyboard reports into a stream of press/release
// events by diffing each report against the last committed one.
//   clk, reset_n          : clock, asynchronous active-low reset
//   rep_valid             : one-cycle strobe, new report on kb_status/kb_dat0..5
//   kb_status, kb_dat0..5 : modifier bitmap and key slots (8'h00 = empty)
//   ev_valid/ev_ready     : event handshake. ev_valid, ev_code and ev_make are
//                           registered; an event transfers on a rising edge
//                           where both are high, and while ev_valid=1 with
//                           ev_ready=0 the presented event is held unchanged.
//   ev_code, ev_make      : HID usage, 1 = press / 0 = release
//   busy                  : FSM not in IDLE
//   overrun, rollover     : one-cycle pulses (pending overwritten / report dropped)
//   dbg_state             : current FSM state
module hid_event_sequencer
  import hid_pkg::*;
#(
  parameter logic [7:0] ROLLOVER_CODE = 8'h01,
  parameter logic [7:0] MOD_BASE      = 8'hE0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rep_valid,
  input  logic [7:0] kb_status,
  input  logic [7:0] kb_dat0,
  input  logic [7:0] kb_dat1,
  input  logic [7:0] kb_dat2,
  input  logic [7:0] kb_dat3,
  input  logic [7:0] kb_dat4,
  input  logic [7:0] kb_dat5,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_make,
  output logic       busy,
  output logic       overrun,
  output logic       rollover,
  output state_t     dbg_state
);
  localparam logic [2:0] LAST_MOD  = 3'(MOD_BITS - 1);
  localparam logic [2:0] LAST_SLOT = 3'(KEY_SLOTS - 1);

  state_t     state, state_nxt;
  logic [2:0] idx;
  logic [2:0] slot;
  logic [7:0] old_mod, cur_mod, pend_mod;
  key_set_t   old_key, cur_key, pend_key, in_key;
  logic       pend_v;

  logic       has_rollover;
  logic       brk_hit, mak_hit;
  logic       ev_due, stall, last_step;
  logic [7:0] nxt_code;
  logic       nxt_make;
  logic       pend_wr, pend_take;

  assign in_key    = {kb_dat5, kb_dat4, kb_dat3, kb_dat2, kb_dat1, kb_dat0};
  assign dbg_state = state;
  // idx runs to 7 in MOD; key-slot lookups only matter for 0..5
  assign slot      = (idx > LAST_SLOT) ? 3'd0 : idx;

  // A pending report is consumed in IDLE; a new strobe lands in pending
  // whenever it cannot be taken directly into cur.
  assign pend_take = (state == IDLE) && pend_v;
  assign pend_wr   = rep_valid && ((state != IDLE) || pend_v);

  hid_key_match u_brk_match (.code(old_key[slot]), .set(cur_key), .hit(brk_hit));
  hid_key_match u_mak_match (.code(cur_key[slot]), .set(old_key), .hit(mak_hit));

  always_comb begin
    has_rollover = 1'b0;
    for (int i = 0; i < KEY_SLOTS; i++) begin
      if (cur_key[i] == ROLLOVER_CODE) has_rollover = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend_v || rep_valid) state_nxt = CAPTURE;
      CAPTURE: state_nxt = has_rollover ? IDLE : MOD;
      MOD:     if (!stall && last_step) state_nxt = BRK;
      BRK:     if (!stall && last_step) state_nxt = MAK;
      MAK:     if (!stall && last_step) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / scan-step decode
  always_comb begin
    ev_due   = 1'b0;
    nxt_code = 8'h00;
    nxt_make = 1'b0;
    case (state)
      MOD: begin
        ev_due   = cur_mod[idx] != old_mod[idx];
        nxt_code = MOD_BASE + {5'd0, idx};
        nxt_make = cur_mod[idx];
      end
      BRK: begin
        ev_due   = (old_key[slot] != 8'h00) && !brk_hit;
        nxt_code = old_key[slot];
        nxt_make = 1'b0;
      end
      MAK: begin
        ev_due   = (cur_key[slot] != 8'h00) && !mak_hit;
        nxt_code = cur_key[slot];
        nxt_make = 1'b1;
      end
      default: ;
    endcase
    // An event that cannot be loaded freezes the scan in place
    stall     = ev_due && ev_valid && !ev_ready;
    last_step = (state == MOD) ? (idx == LAST_MOD) : (idx == LAST_SLOT);
    busy      = state != IDLE;
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= 3'd0;
      old_mod  <= 8'h00;
      old_key  <= '0;
      cur_mod  <= 8'h00;
      cur_key  <= '0;
      pend_mod <= 8'h00;
      pend_key <= '0;
      pend_v   <= 1'b0;
      ev_valid <= 1'b0;
      ev_code  <= 8'h00;
      ev_make  <= 1'b0;
      overrun  <= 1'b0;
      rollover <= 1'b0;
    end else begin
      if (state inside {MOD, BRK, MAK}) begin
        if (!stall) idx <= last_step ? 3'd0 : idx + 3'd1;
      end else begin
        idx <= 3'd0;
      end

      if (ev_due && !stall) begin
        ev_valid <= 1'b1;
        ev_code  <= nxt_code;
        ev_make  <= nxt_make;
      end else if (ev_ready) begin
        ev_valid <= 1'b0;
      end

      if (state == IDLE) begin
        if (pend_v) begin
          cur_mod <= pend_mod;
          cur_key <= pend_key;
        end else if (rep_valid) begin
          cur_mod <= kb_status;
          cur_key <= in_key;
        end
      end

      // Latest report wins; overwriting an unconsumed pending report is an overrun
      if (pend_wr) begin
        pend_mod <= kb_status;
        pend_key <= in_key;
        pend_v   <= 1'b1;
      end else if (pend_take) begin
        pend_v <= 1'b0;
      end
      overrun  <= pend_wr && pend_v && !pend_take;
      rollover <= (state == CAPTURE) && has_rollover;

      if (state == COMMIT) begin
        old_mod <= cur_mod;
        old_key <= cur_key;
      end
    end
  end
endmodule

// File: tb/tb_hid_event_sequencer.sv
// Directed bench for hid_event_sequencer: a table of successive reports with
// hand-computed event lists, plus sequences for stall, overrun and mid-scan reset.
module tb_hid_event_sequencer;
  import hid_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rep_valid = 1'b0;
  logic [7:0] kb_status = 8'h00;
  logic [7:0] kb_dat0 = 8'h00, kb_dat1 = 8'h00, kb_dat2 = 8'h00;
  logic [7:0] kb_dat3 = 8'h00, kb_dat4 = 8'h00, kb_dat5 = 8'h00;
  logic       ev_valid, ev_make, busy, overrun, rollover;
  logic       ev_ready = 1'b1;
  logic [7:0] ev_code;
  state_t     dbg_state;

  always #5 clk = ~clk;

  hid_event_sequencer #(.ROLLOVER_CODE(8'h01), .MOD_BASE(8'hE0)) dut (
    .clk(clk), .reset_n(reset_n), .rep_valid(rep_valid), .kb_status(kb_status),
    .kb_dat0(kb_dat0), .kb_dat1(kb_dat1), .kb_dat2(kb_dat2),
    .kb_dat3(kb_dat3), .kb_dat4(kb_dat4), .kb_dat5(kb_dat5),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_make(ev_make),
    .busy(busy), .overrun(overrun), .rollover(rollover), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int got_base = 0;
  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int roll_cnt = 0;
  int ovr_cnt = 0;

  // Sampled on the falling edge: an event seen here transfers on the next rise
  always @(negedge clk) begin
    if (ev_valid && ev_ready) got_q.push_back({ev_make, ev_code});
    if (busy) busy_cnt++;
    if (rollover) roll_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_events(input string name);
    int n;
    n = got_q.size() - got_base;
    chk({name, " event count"}, 32'(n), 32'(exp_q.size()));
    for (int k = 0; k < n && k < exp_q.size(); k++)
      chk({name, " event"}, {23'd0, got_q[got_base + k]}, {23'd0, exp_q[k]});
    got_base = got_q.size();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, " ev_valid"}, {31'd0, ev_valid}, 32'd0);
    chk({name, " ev_code"}, {24'd0, ev_code}, 32'd0);
    chk({name, " ev_make"}, {31'd0, ev_make}, 32'd0);
    chk({name, " busy"}, {31'd0, busy}, 32'd0);
    chk({name, " overrun"}, {31'd0, overrun}, 32'd0);
    chk({name, " rollover"}, {31'd0, rollover}, 32'd0);
    chk({name, " state"}, {29'd0, dbg_state}, {29'd0, IDLE});
  endtask

  // ---------------- driver tasks ----------------
  function automatic key_set_t ks(input logic [7:0] a, b, c, d, e, f);
    key_set_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_report(input logic [7:0] mod, input key_set_t keys);
    tick();
    rep_valid = 1'b1;
    kb_status = mod;
    kb_dat0 = keys[0]; kb_dat1 = keys[1]; kb_dat2 = keys[2];
    kb_dat3 = keys[3]; kb_dat4 = keys[4]; kb_dat5 = keys[5];
    tick();
    rep_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk({name, " idle timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_state(input state_t s, input string name);
    int n = 0;
    while (dbg_state != s && n < 100) begin
      tick();
      n++;
    end
    chk({name, " reach state"}, {29'd0, dbg_state}, {29'd0, s});
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    got_base = got_q.size();
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]       mod;
    key_set_t         keys;
    int               n_ev;
    logic [7:0][8:0]  ev;
    int               n_roll;
    int               n_busy;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  task automatic set_vec(input int i, input logic [7:0] mod, input key_set_t keys,
                         input int n_ev, input int n_roll, input int n_busy);
    vecs[i].mod = mod;
    vecs[i].keys = keys;
    vecs[i].n_ev = n_ev;
    vecs[i].ev = '0;
    vecs[i].n_roll = n_roll;
    vecs[i].n_busy = n_busy;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, r0, o0;

    // Each report is diffed against the previous row's report (zero after reset)
    set_vec(0, 8'h02, ks(8'h04, 0, 0, 0, 0, 0), 2, 0, 22);
    vecs[0].ev[0] = {1'b1, 8'hE1}; vecs[0].ev[1] = {1'b1, 8'h04};
    set_vec(1, 8'h02, ks(8'h04, 8'h05, 0, 0, 0, 0), 1, 0, 22);
    vecs[1].ev[0] = {1'b1, 8'h05};
    set_vec(2, 8'h02, ks(8'h05, 8'h06, 0, 0, 0, 0), 2, 0, 22);
    vecs[2].ev[0] = {1'b0, 8'h04}; vecs[2].ev[1] = {1'b1, 8'h06};
    set_vec(3, 8'h03, ks(8'h06, 8'h06, 0, 0, 0, 0), 2, 0, 22);
    vecs[3].ev[0] = {1'b1, 8'hE0}; vecs[3].ev[1] = {1'b0, 8'h05};
    set_vec(4, 8'h00, ks(0, 0, 0, 0, 0, 0), 4, 0, 22);
    vecs[4].ev[0] = {1'b0, 8'hE0}; vecs[4].ev[1] = {1'b0, 8'hE1};
    vecs[4].ev[2] = {1'b0, 8'h06}; vecs[4].ev[3] = {1'b0, 8'h06};
    set_vec(5, 8'h80, ks(8'h08, 8'h08, 8'h09, 0, 0, 0), 4, 0, 22);
    vecs[5].ev[0] = {1'b1, 8'hE7}; vecs[5].ev[1] = {1'b1, 8'h08};
    vecs[5].ev[2] = {1'b1, 8'h08}; vecs[5].ev[3] = {1'b1, 8'h09};
    set_vec(6, 8'h00, ks(8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01), 0, 1, 1);
    set_vec(7, 8'h00, ks(0, 0, 0, 0, 0, 0), 4, 0, 22);
    vecs[7].ev[0] = {1'b0, 8'hE7}; vecs[7].ev[1] = {1'b0, 8'h08};
    vecs[7].ev[2] = {1'b0, 8'h08}; vecs[7].ev[3] = {1'b0, 8'h09};

    do_reset();

    for (int i = 0; i < NV; i++) begin
      b0 = busy_cnt;
      r0 = roll_cnt;
      drive_report(vecs[i].mod, vecs[i].keys);
      wait_idle($sformatf("vec%0d", i));
      repeat (3) tick();
      for (int k = 0; k < vecs[i].n_ev; k++) exp_q.push_back(vecs[i].ev[k]);
      check_events($sformatf("vec%0d", i));
      chk($sformatf("vec%0d busy cycles", i), 32'(busy_cnt - b0), 32'(vecs[i].n_busy));
      chk($sformatf("vec%0d rollover pulses", i), 32'(roll_cnt - r0), 32'(vecs[i].n_roll));
      chk($sformatf("vec%0d ev_valid drained", i), {31'd0, ev_valid}, 32'd0);
    end

    // Backpressure on the first event: output held, scan frozen in MOD
    do_reset();
    ev_ready = 1'b0;
    drive_report(8'h03, ks(8'h04, 0, 0, 0, 0, 0));
    for (int n = 0; n < 20 && !ev_valid; n++) tick();
    chk("stall ev_valid seen", {31'd0, ev_valid}, 32'd1);
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("stall ev_valid", {31'd0, ev_valid}, 32'd1);
      chk("stall ev_code", {24'd0, ev_code}, 32'hE0);
      chk("stall ev_make", {31'd0, ev_make}, 32'd1);
      chk("stall state", {29'd0, dbg_state}, {29'd0, MOD});
    end
    ev_ready = 1'b1;
    wait_idle("stall");
    repeat (3) tick();
    exp_q.push_back({1'b1, 8'hE0});
    exp_q.push_back({1'b1, 8'hE1});
    exp_q.push_back({1'b1, 8'h04});
    check_events("stall drain");

    // Three strobes during one scan: second is overwritten by the third
    do_reset();
    o0 = ovr_cnt;
    drive_report(8'h00, ks(8'h04, 0, 0, 0, 0, 0));
    repeat (3) tick();
    drive_report(8'h00, ks(8'h05, 0, 0, 0, 0, 0));
    drive_report(8'h00, ks(8'h06, 0, 0, 0, 0, 0));
    repeat (70) tick();
    exp_q.push_back({1'b1, 8'h04});
    exp_q.push_back({1'b0, 8'h04});
    exp_q.push_back({1'b1, 8'h06});
    check_events("overrun");
    chk("overrun pulses", 32'(ovr_cnt - o0), 32'd1);
    chk("overrun idle", {31'd0, busy}, 32'd0);

    // Reset asserted mid-BRK with a report pending: everything discarded
    drive_report(8'h00, ks(8'h04, 8'h05, 0, 0, 0, 0));
    drive_report(8'h00, ks(8'h09, 0, 0, 0, 0, 0));
    wait_state(BRK, "midbrk");
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midbrk reset");
    got_base = got_q.size();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) tick();
    check_events("after midbrk reset");
    chk("after midbrk busy", {31'd0, busy}, 32'd0);
    // Old state was {06}; after reset the diff base is zero so 06 is a press
    drive_report(8'h00, ks(8'h06, 0, 0, 0, 0, 0));
    wait_idle("post reset");
    repeat (3) tick();
    exp_q.push_back({1'b1, 8'h06});
    check_events("post reset diff");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hid_event_sequencer.md
HID_EVENT_SEQUENCER -- requirements
Module: hid_event_sequencer

Interface
REQ-001 Parameter ROLLOVER_CODE, default 8'h01, HID usage that marks a phantom or overflow report.
REQ-002 Parameter MOD_BASE, default 8'hE0, usage code emitted for modifier bit 0; bit i emits MOD_BASE+i.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 rep_valid  in  1  one-cycle strobe; a new HID boot report is present on kb_status and kb_dat0..5.
REQ-006 kb_status  in  8  modifier bitmap of the report.
REQ-007 kb_dat0..kb_dat5  in  8 each  key slots of the report; 8'h00 means empty.
REQ-008 ev_valid  out  1  an event is presented.
REQ-009 ev_ready  in  1  the consumer (scancode buffer) accepts the event.
REQ-010 ev_code  out  8  HID usage of the event.
REQ-011 ev_make  out  1  1 = press, 0 = release.
REQ-012 busy  out  1  high in any state except IDLE.
REQ-013 overrun  out  1  one-cycle pulse when a pending report is overwritten.
REQ-014 rollover  out  1  one-cycle pulse when a report is discarded as rollover.

Function
REQ-015 The block SHALL keep the last committed report (old_mod, old_key[0..5]) and a one-deep pending report register with a pend_v flag.
REQ-016 FSM states SHALL be IDLE, CAPTURE, MOD, BRK, MAK and COMMIT.
REQ-017 In IDLE, pend_v=1 -> load cur from pending, clear pend_v, go to CAPTURE; else rep_valid=1 -> load cur from inputs, go to CAPTURE.
REQ-018 rep_valid outside IDLE, or coincident with the pending load in IDLE, SHALL write pending; if pend_v was already 1 and not being consumed, pulse overrun (latest report wins).
REQ-019 CAPTURE: any cur key slot == ROLLOVER_CODE -> pulse rollover, keep old, return to IDLE; else go to MOD with idx=0.
REQ-020 MOD: per cycle test bit idx; cur_mod[idx] != old_mod[idx] -> event (MOD_BASE+idx, cur_mod[idx]); idx 0..7, then go to BRK with idx=0.
REQ-021 BRK: per cycle slot idx; old_key[idx] != 0 and absent from all cur slots -> event (old_key[idx], 0); idx 0..5, then go to MAK with idx=0.
REQ-022 MAK: per cycle slot idx; cur_key[idx] != 0 and absent from all old slots -> event (cur_key[idx], 1); idx 0..5, then go to COMMIT.
REQ-023 Duplicate nonzero codes inside one report SHALL each generate an event per slot, with no deduplication.
REQ-024 COMMIT: old <= cur in one cycle, then go to IDLE.
REQ-025 Event handshake:
- ev_valid/ev_code/ev_make are registered.
- An event is loaded when ev_valid=0 or ev_ready=1, and idx advances in that cycle.
- If an event is due while ev_valid=1 and ev_ready=0, the FSM SHALL stall with idx, ev_code and ev_make held stable.
REQ-026 A cycle with no event due SHALL clear ev_valid if ev_ready=1, and always advance idx.
REQ-027 With ev_ready tied high, a report SHALL take exactly 22 cycles from IDLE to IDLE (1 CAPTURE + 8 + 6 + 6 + 1 COMMIT).
REQ-028 Each event SHALL appear one cycle after its scan step.
REQ-029 ev_valid may remain high across COMMIT and IDLE until accepted.
REQ-030 Ordering SHALL be all modifier events, then all breaks, then all makes.

Reset
REQ-031 reset_n low SHALL force IDLE, idx=0, pend_v=0, old_mod=0, old_key=all 0, ev_valid=0, ev_code=0, ev_make=0, overrun=0, rollover=0 and busy=0.
REQ-032 Reset mid-scan SHALL discard the in-flight and pending reports with no further events.
REQ-033 After reset, the first report SHALL be diffed against all-zero.

Structure
REQ-034 A shared package hid_pkg SHALL hold the state encoding, KEY_SLOTS=6 and MOD_BITS=8.
REQ-035 The sub-module hid_key_match SHALL perform the combinational "byte present in 6-slot set" test, instantiated twice (BRK uses the cur set, MAK uses the old set).

Verification
REQ-036 After reset, report mod=8'h02, keys {04,00,00,00,00,00}, ev_ready=1 -> events (E1,1), (04,1); busy for 22 cycles.
REQ-037 Old {04,05}, new {05,06} -> exactly (04,0) then (06,1); no event for 05.
REQ-038 Report with all slots 8'h01 -> rollover pulse, no events; a following empty report releases all previously held keys.
REQ-039 ev_ready=0 for 10 cycles on the first event -> ev_valid/ev_code/ev_make stable, FSM stalled; on release the events drain in order.
REQ-040 Three rep_valid strobes during one scan -> one overrun pulse; only the third report is processed after the first.
REQ-041 reset_n asserted mid-BRK -> all outputs at reset values asynchronously; the next report diffs against zero.
